eight_bit_adder: RTL and testbench

- Registered two's-complement adder: sums operands a and b and reports signed overflow and unsigned carry.
- Arithmetic is ripple-carry, built from a full-adder cell chain.
- Results are registered with one cycle of latency and a simple valid flag.
- Used as a datapath leaf wherever an 8-bit signed add with overflow detection is needed.

---
 rtl/eight_bit_adder_pkg.sv | 12 +
 rtl/eight_bit_adder_if.sv | 27 ++
 rtl/adder_full_cell.sv | 17 +
 rtl/eight_bit_adder.sv | 68 ++++++
 tb/tb_eight_bit_adder.sv | 111 +++++++++++
 5 files changed

// File: rtl/eight_bit_adder_pkg.sv
// Shared constants and types for the registered 8-bit two's-complement adder.
// Saturation bounds are only consumed when EIGHT_BIT_ADDER_SATURATE_EN is defined.
package eight_bit_adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH-1:0] adder_word_t;

  localparam adder_word_t SAT_MAX = 8'h7F;
  localparam adder_word_t SAT_MIN = 8'h80;

endpackage

// File: rtl/eight_bit_adder_if.sv
// Operand/result bundle for eight_bit_adder; master drives operands, slave returns results.
// No backpressure: in_valid is accepted every cycle, out_valid is a one-cycle strobe.
interface eight_bit_adder_if
  import eight_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             overflow;
  logic             carry_out;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  s, overflow, carry_out, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output s, overflow, carry_out, out_valid
  );

endinterface

// File: rtl/adder_full_cell.sv
// One-bit full adder, the ripple-chain building block.
// Purely combinational, no latency, no backpressure.
module adder_full_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/eight_bit_adder.sv
// Registered ripple-carry two's-complement adder with signed overflow and carry out.
// Latency 1 cycle, full throughput, no backpressure; EIGHT_BIT_ADDER_SATURATE_EN clamps s on overflow.
module eight_bit_adder
  import eight_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  eight_bit_adder_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_d;
  logic             ovf;

  logic [WIDTH-1:0] s_q;
  logic             ovf_q;
  logic             carry_q;
  logic             vld_q;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    adder_full_cell u_cell (
      .a    (bus.a[gi]),
      .b    (bus.b[gi]),
      .cin  (carry[gi]),
      .s    (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  // Carry into the MSB differing from carry out of it is exactly signed overflow.
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef EIGHT_BIT_ADDER_SATURATE_EN
  // Operands share a sign on overflow, so a's MSB gives the clamp direction.
  assign s_d = !ovf          ? sum :
               bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign s_d = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q     <= s_d;
        ovf_q   <= ovf;
        carry_q <= carry[WIDTH];
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = carry_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Randomized self-checking bench for eight_bit_adder against an integer-arithmetic reference.
module tb_eight_bit_adder;
  import eight_bit_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  adder_word_t m_s   = '0;
  logic        m_ovf = 1'b0;
  logic        m_c   = 1'b0;
  logic        m_vld = 1'b0;

  eight_bit_adder_if #(.WIDTH(8)) bus ();

  eight_bit_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".s"},         32'(bus.s),         32'(m_s));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    check({tag, ".carry_out"}, 32'(bus.carry_out), 32'(m_c));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
  endtask

  // Called at a falling edge: drive operands, update the reference, sample at the next falling edge.
  task automatic apply(input string tag, input logic v, input adder_word_t ia, input adder_word_t ib);
    int ssum;
    int usum;
    bus.in_valid = v;
    bus.a        = ia;
    bus.b        = ib;
    if (v) begin
      ssum  = int'($signed(ia)) + int'($signed(ib));
      usum  = int'(ia) + int'(ib);
      m_ovf = (ssum > 127) || (ssum < -128);
      m_c   = (usum > 255);
      m_s   = 8'(usum);
`ifdef EIGHT_BIT_ADDER_SATURATE_EN
      if (ssum > 127)       m_s = SAT_MAX;
      else if (ssum < -128) m_s = SAT_MIN;
`endif
    end
    m_vld = v;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.a        = 8'h55;
    bus.b        = 8'h22;

    // Reset held across an edge: outputs stay cleared even with in_valid high.
    @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    apply("dir_01_01", 1'b1, 8'h01, 8'h01);
    apply("dir_40_40", 1'b1, 8'h40, 8'h40);
    apply("dir_80_80", 1'b1, 8'h80, 8'h80);
    apply("dir_ff_ff", 1'b1, 8'hFF, 8'hFF);
    apply("dir_7f_01", 1'b1, 8'h7F, 8'h01);
    apply("dir_ff_01", 1'b1, 8'hFF, 8'h01);
    apply("dir_80_7f", 1'b1, 8'h80, 8'h7F);
    apply("dir_7f_7f", 1'b1, 8'h7F, 8'h7F);

    for (int i = 0; i < 4; i++)
      apply("b2b_valid", 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++)
      apply("b2b_hold", 1'b0, 8'($urandom), 8'($urandom));

    for (int i = 0; i < 300; i++)
      apply("random", ($urandom_range(3, 0) != 0), 8'($urandom), 8'($urandom));

    // Make sure something nonzero is registered before the mid-stream reset.
    apply("pre_reset", 1'b1, 8'h12, 8'h34);
    #2 rst = 1'b1;
    #1;
    m_s = '0; m_ovf = 1'b0; m_c = 1'b0; m_vld = 1'b0;
    check_outputs("async_reset");
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("reset_held");
    rst = 1'b0;
    apply("post_reset", 1'b1, 8'hC0, 8'hC0);
    apply("post_reset_idle", 1'b0, 8'h00, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
